// File: rtl/z80_busreq_arbiter.sv
// Z80 bus arbiter: shares the CPU bus with external masters through
// the BUSREQ_L/BUSACK_L handshake, round-robin, bounded tenure.
module z80_busreq_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 64,
    parameter int CPU_MIN   = 8
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] gnt,
    output logic                 ext_en,
    output logic [2:0]           owner,
    output logic                 timeout,
    output logic                 BUSREQ_L,
    input  logic                 BUSACK_L
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int CW = (CPU_MIN > 0) ? $clog2(CPU_MIN + 1) : 1;

    localparam logic [HW-1:0] HOLD_LAST =
        HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HW-1:0] HOLD_SAT  = '1;
    localparam logic [CW-1:0] CPU_LOAD  = CW'(CPU_MIN);
    localparam logic [2:0]    LAST_IDX  = 3'(N_MASTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_DRAIN,
        S_RELEASE,
        S_CPU_HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]           rr_ptr;
    logic [2:0]           rr_d;
    logic [HW-1:0]        hold_cnt;
    logic [HW-1:0]        hold_d;
    logic [CW-1:0]        cpu_cnt;
    logic [CW-1:0]        cpu_d;
    logic [N_MASTERS-1:0] gnt_d;
    logic                 ext_en_d;
    logic [2:0]           owner_d;
    logic                 timeout_d;
    logic                 busreq_d;

    logic [N_MASTERS-1:0] owner_mask;
    logic                 req_own;
    logic [N_MASTERS-1:0] req_rot;
    logic                 pick_ok;
    logic [2:0]           pick_idx;
    logic                 hold_hit;
    logic [2:0]           rr_next;

    function automatic logic [2:0] wrap_idx(input int s);
        if (s >= N_MASTERS) begin
            return 3'(s - N_MASTERS);
        end
        return 3'(s);
    endfunction

    assign owner_mask = N_MASTERS'(1) << owner;
    assign req_own    = |(req & owner_mask);
    assign req_rot    = N_MASTERS'({req, req} >> rr_ptr);
    assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign rr_next    = (owner == LAST_IDX) ? 3'd0 : owner + 3'd1;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = rr_ptr;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_ok  = 1'b1;
                pick_idx = wrap_idx(int'(rr_ptr) + i);
            end
        end
    end

    // State and output registers; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q  <= S_IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            cpu_cnt  <= '0;
            gnt      <= '0;
            ext_en   <= 1'b0;
            owner    <= '0;
            timeout  <= 1'b0;
            BUSREQ_L <= 1'b1;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_d;
            hold_cnt <= hold_d;
            cpu_cnt  <= cpu_d;
            gnt      <= gnt_d;
            ext_en   <= ext_en_d;
            owner    <= owner_d;
            timeout  <= timeout_d;
            BUSREQ_L <= busreq_d;
        end
    end

    // Next-state and next-output logic for the bus handshake.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_ptr;
        hold_d    = hold_cnt;
        cpu_d     = cpu_cnt;
        gnt_d     = gnt;
        ext_en_d  = ext_en;
        owner_d   = owner;
        timeout_d = 1'b0;
        busreq_d  = BUSREQ_L;
        unique case (state_q)
            S_IDLE: begin
                busreq_d = 1'b1;
                if (pick_ok && cpu_cnt == '0) begin
                    owner_d  = pick_idx;
                    busreq_d = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // Never abandon a request the CPU may be acting on.
                busreq_d = 1'b0;
                if (!BUSACK_L) begin
                    if (req_own) begin
                        gnt_d    = owner_mask;
                        ext_en_d = 1'b1;
                        hold_d   = '0;
                        state_d  = S_GRANT;
                    end else begin
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_GRANT: begin
                busreq_d = 1'b0;
                if (hold_cnt != HOLD_SAT) begin
                    hold_d = hold_cnt + HW'(1);
                end
                if (!req_own || hold_hit) begin
                    gnt_d     = '0;
                    ext_en_d  = 1'b0;
                    timeout_d = req_own;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // One dead cycle for the master's drivers to turn off.
                rr_d     = rr_next;
                busreq_d = 1'b1;
                state_d  = S_RELEASE;
            end
            S_RELEASE: begin
                busreq_d = 1'b1;
                if (BUSACK_L) begin
                    cpu_d   = CPU_LOAD;
                    state_d = S_CPU_HOLD;
                end
            end
            S_CPU_HOLD: begin
                busreq_d = 1'b1;
                if (cpu_cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cpu_d = cpu_cnt - CW'(1);
                end
            end
            default: begin
                gnt_d    = '0;
                ext_en_d = 1'b0;
                busreq_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Grant outputs stay consistent with each other and the handshake.
    a_onehot: assert property (
        @(posedge clk) disable iff (!rst_L) $onehot0(gnt));
    a_ext_en: assert property (
        @(posedge clk) disable iff (!rst_L) ext_en == (|gnt));
    a_busreq: assert property (
        @(posedge clk) disable iff (!rst_L) (|gnt) |-> !BUSREQ_L);

endmodule
